// File: rtl/tspi_pkg.sv
// Shared types and constants for the TSPI target and controller blocks.
package tspi_pkg;

  localparam int unsigned TSPI_HDR_W = 8;
  localparam int unsigned TSPI_LEN_W = 6;

  localparam logic [1:0] TSPI_OP_WRITE = 2'b00;
  localparam logic [1:0] TSPI_OP_READ  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WDATA,
    TURN,
    RDATA
  } tspi_tgt_state_e;

  // Opcodes 10 and 11 are reserved.
  function automatic logic tspi_op_reserved(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/tspi_edge_detect.sv
// Rise/fall strobes for a signal already synchronous to clk_i.
module tspi_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic r_sig_q;

  // Delayed copy of the input, compared against the live value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sig_q <= 1'b0;
    else         r_sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~r_sig_q;
  assign fall_o = ~sig_i & r_sig_q;

endmodule

// File: rtl/tspi_target.sv
// TSPI target: start bit, 8-bit header (opcode + length), then a write
// payload received into rx_* or a read payload taken from tx_* and shifted
// out after a one-bit turnaround. Inputs are sampled on bit-clock rises,
// the output line only changes on bit-clock falls.
module tspi_target
  import tspi_pkg::*;
#(
  parameter int unsigned DataWidth = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tspi_clk_i,
  input  logic                  tspi_data_i,
  output logic                  tspi_data_o,
  output logic                  tspi_data_oe_o,
  output logic [DataWidth-1:0]  rx_data_o,
  output logic [TSPI_LEN_W-1:0] rx_len_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  input  logic [DataWidth-1:0]  tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  overrun_o,
  output logic                  underrun_o,
  output logic                  hdr_err_o,
  input  logic                  clear_i
);

  localparam logic [TSPI_LEN_W-1:0] HdrLastBit = TSPI_LEN_W'(TSPI_HDR_W - 1);
  localparam logic [TSPI_LEN_W-1:0] CntOne     = TSPI_LEN_W'(1);

  tspi_tgt_state_e r_state, w_state_next;

  logic                  w_rise;
  logic                  w_fall;
  logic [TSPI_HDR_W-1:0] w_hdr_next;
  logic [1:0]            w_opcode;
  logic                  w_hdr_last;
  logic                  w_wr_last;
  logic                  w_rd_last;
  logic [TSPI_LEN_W-1:0] w_rd_idx;
  logic [DataWidth-1:0]  w_wr_next;

  // Only the low seven header bits need storing; the eighth arrives live.
  logic [TSPI_HDR_W-2:0] r_hdr;
  logic [TSPI_LEN_W-1:0] r_bit_cnt;
  logic [TSPI_LEN_W-1:0] r_len;
  logic [DataWidth-1:0]  r_shift;
  logic [DataWidth-1:0]  r_rx_data;
  logic [TSPI_LEN_W-1:0] r_rx_len;
  logic                  r_rx_valid;
  logic                  r_tx_ready;
  logic                  r_data_o;
  logic                  r_oe;
  logic                  r_overrun;
  logic                  r_underrun;
  logic                  r_hdr_err;

  tspi_edge_detect u_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sig_i  (tspi_clk_i),
    .rise_o (w_rise),
    .fall_o (w_fall)
  );

  assign w_hdr_next = {r_hdr, tspi_data_i};
  assign w_opcode   = w_hdr_next[TSPI_HDR_W-1 -: 2];
  assign w_wr_next  = {r_shift[DataWidth-2:0], tspi_data_i};
  // Fall k of the read phase follows k rises, so it drives bit len-k.
  assign w_rd_idx   = r_len - r_bit_cnt;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state decode and end-of-phase strobes.
  always_comb begin
    w_state_next = r_state;
    w_hdr_last   = 1'b0;
    w_wr_last    = 1'b0;
    w_rd_last    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && !tspi_data_i) w_state_next = HEADER;
      end
      HEADER: begin
        if (w_rise && (r_bit_cnt == HdrLastBit)) begin
          w_hdr_last = 1'b1;
          if (tspi_op_reserved(w_opcode))  w_state_next = IDLE;
          else if (w_opcode == TSPI_OP_READ) w_state_next = TURN;
          else                               w_state_next = WDATA;
        end
      end
      WDATA: begin
        if (w_rise && (r_bit_cnt == r_len)) begin
          w_wr_last    = 1'b1;
          w_state_next = IDLE;
        end
      end
      TURN: begin
        if (w_rise) w_state_next = RDATA;
      end
      RDATA: begin
        if (w_rise && (r_bit_cnt == r_len)) begin
          w_rd_last    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (clear_i) w_state_next = IDLE;
  end

  // Datapath: counters, shift register, rx/tx handshakes, line drive, flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hdr      <= '0;
      r_bit_cnt  <= '0;
      r_len      <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_rx_len   <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_data_o   <= 1'b0;
      r_oe       <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_hdr_err  <= 1'b0;
    end else if (clear_i) begin
      r_bit_cnt  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_oe       <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_hdr_err  <= 1'b0;
    end else begin
      r_tx_ready <= 1'b0;
      if (r_rx_valid && rx_ready_i) r_rx_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_rise && !tspi_data_i) r_bit_cnt <= '0;
        end
        HEADER: begin
          if (w_rise) begin
            r_hdr <= w_hdr_next[TSPI_HDR_W-2:0];
            if (w_hdr_last) begin
              r_bit_cnt <= '0;
              r_len     <= w_hdr_next[TSPI_LEN_W-1:0];
              r_shift   <= '0;
              if (tspi_op_reserved(w_opcode))    r_hdr_err  <= 1'b1;
              else if (w_opcode == TSPI_OP_READ) r_tx_ready <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + CntOne;
            end
          end
        end
        WDATA: begin
          if (w_rise) begin
            r_shift <= w_wr_next;
            if (w_wr_last) begin
              // A completion coinciding with a consuming handshake replaces
              // the old payload; the valid-clear above is overridden here.
              if (r_rx_valid && !rx_ready_i) begin
                r_overrun <= 1'b1;
              end else begin
                r_rx_data  <= w_wr_next;
                r_rx_len   <= r_len;
                r_rx_valid <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + CntOne;
            end
          end
        end
        TURN: begin
          // tx_ready_o is high exactly in the first TURN cycle.
          if (r_tx_ready) begin
            if (tx_valid_i) begin
              r_shift <= tx_data_i;
            end else begin
              r_shift    <= '0;
              r_underrun <= 1'b1;
            end
          end
          if (w_rise) r_bit_cnt <= '0;
        end
        RDATA: begin
          if (w_fall) begin
            r_data_o <= r_shift[w_rd_idx];
            r_oe     <= 1'b1;
          end
          if (w_rise) begin
            if (w_rd_last) r_oe      <= 1'b0;
            else           r_bit_cnt <= r_bit_cnt + CntOne;
          end
        end
        default: r_bit_cnt <= '0;
      endcase
    end
  end

  assign tspi_data_o    = r_data_o;
  assign tspi_data_oe_o = r_oe;
  assign rx_data_o      = r_rx_data;
  assign rx_len_o       = r_rx_len;
  assign rx_valid_o     = r_rx_valid;
  assign tx_ready_o     = r_tx_ready;
  assign overrun_o      = r_overrun;
  assign underrun_o     = r_underrun;
  assign hdr_err_o      = r_hdr_err;

endmodule

// File: tb/tb_tspi_target.sv
// Bench for tspi_target: a vector table of write/read frames plus directed
// sequences for overrun, header error, clear and reset during a frame.
module tb_tspi_target;

  localparam int HALF = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tspi_clk;
  logic        tspi_din;
  logic        tspi_dout;
  logic        tspi_oe;
  logic [63:0] rx_data;
  logic [5:0]  rx_len;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overrun;
  logic        underrun;
  logic        hdr_err;
  logic        clear;

  int n_checks = 0;
  int n_errors = 0;
  int n_txr    = 0;

  typedef struct {
    logic [63:0] data;
    logic [5:0]  len;
  } rx_exp_t;

  typedef struct {
    bit          rd;
    logic [7:0]  hdr;
    logic [63:0] data;
    bit          txv;
    bit          exp_ur;
  } vec_t;

  rx_exp_t     exp_rx[$];
  logic [63:0] exp_rd[$];
  vec_t        vecs[7];

  always #5 clk = ~clk;

  tspi_target #(.DataWidth(64)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tspi_clk_i     (tspi_clk),
    .tspi_data_i    (tspi_din),
    .tspi_data_o    (tspi_dout),
    .tspi_data_oe_o (tspi_oe),
    .rx_data_o      (rx_data),
    .rx_len_o       (rx_len),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .overrun_o      (overrun),
    .underrun_o     (underrun),
    .hdr_err_o      (hdr_err),
    .clear_i        (clear)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every rx handshake pops the oldest expected write payload.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rx_unexpected: got %h expected no payload", rx_data);
      end else begin
        rx_exp_t e;
        e = exp_rx.pop_front();
        chk("rx_data", rx_data, e.data);
        chk("rx_len", {58'd0, rx_len}, {58'd0, e.len});
      end
    end
    if (tx_ready) n_txr++;
  end

  function automatic logic [63:0] mask_n(input int n);
    logic [63:0] m;
    if (n >= 64) m = '1;
    else         m = (64'd1 << n) - 64'd1;
    return m;
  endfunction

  // One bit period: fall with new data, then rise where the line is sampled.
  task automatic tspi_bit(input logic b, input bit rdy_at_rise, output logic so, output logic soe);
    @(posedge clk); #1;
    tspi_clk = 1'b0;
    tspi_din = b;
    repeat (HALF) @(posedge clk);
    #1;
    tspi_clk = 1'b1;
    if (rdy_at_rise) rx_ready = 1'b1;
    so  = tspi_dout;
    soe = tspi_oe;
    repeat (HALF - 1) @(posedge clk);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input bit rdy_last);
    logic so, soe;
    for (int i = n - 1; i >= 0; i--) tspi_bit(v[i], rdy_last && (i == 0), so, soe);
  endtask

  task automatic send_hdr(input logic [7:0] hdr);
    send_bits(64'd0, 1, 1'b0);
    send_bits({56'd0, hdr}, 8, 1'b0);
  endtask

  task automatic line_idle();
    @(posedge clk); #1;
    tspi_clk = 1'b1;
    tspi_din = 1'b1;
  endtask

  task automatic send_write(input logic [7:0] hdr, input logic [63:0] data, input bit rdy_last);
    send_hdr(hdr);
    send_bits(data, int'(hdr[5:0]) + 1, rdy_last);
    line_idle();
  endtask

  task automatic wait_rx_drain(input string name);
    for (int c = 0; c < 40 && exp_rx.size() != 0; c++) @(posedge clk);
    #1;
    chk(name, 64'(exp_rx.size()), 64'd0);
  endtask

  task automatic do_read(input logic [7:0] hdr, input logic [63:0] tx, input logic txv);
    int          nbits;
    int          oecnt;
    int          txr0;
    logic [63:0] got;
    logic [63:0] e;
    logic        so, soe;
    nbits = int'(hdr[5:0]) + 1;
    exp_rd.push_back(txv ? (tx & mask_n(nbits)) : 64'd0);
    tx_data  = tx;
    tx_valid = txv;
    txr0     = n_txr;
    send_hdr(hdr);
    tspi_bit(1'b1, 1'b0, so, soe);
    chk("turn_oe", {63'd0, soe}, 64'd0);
    got   = '0;
    oecnt = 0;
    for (int i = 0; i < nbits; i++) begin
      tspi_bit(1'b1, 1'b0, so, soe);
      got = {got[62:0], so};
      if (soe) oecnt++;
    end
    line_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("oe_after", {63'd0, tspi_oe}, 64'd0);
    e = exp_rd.pop_front();
    chk("rd_data", got, e);
    chk("rd_oe_bits", 64'(oecnt), 64'(nbits));
    chk("tx_ready_pulses", 64'(n_txr - txr0), 64'd1);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic so, soe;
    rst_n    = 1'b0;
    tspi_clk = 1'b1;
    tspi_din = 1'b1;
    rx_ready = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    clear    = 1'b0;

    vecs[0] = '{1'b0, 8'h07, 64'h0000_0000_0000_00A5, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h4F, 64'h0000_0000_0000_BEEF, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h47, 64'h0000_0000_0000_00C3, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'h3F, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 64'h0000_0000_0000_0001, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h7F, 64'h8000_0000_0000_0001, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h0F, 64'h0000_0000_0000_1234, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", {63'd0, tspi_oe}, 64'd0);
    chk("rst_dout", {63'd0, tspi_dout}, 64'd0);
    chk("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
    chk("rst_tx_ready", {63'd0, tx_ready}, 64'd0);
    chk("rst_flags", {61'd0, overrun, underrun, hdr_err}, 64'd0);
    chk("rst_rx_data", rx_data, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rd) begin
        do_read(vecs[v].hdr, vecs[v].data, vecs[v].txv);
      end else begin
        exp_rx.push_back('{vecs[v].data & mask_n(int'(vecs[v].hdr[5:0]) + 1), vecs[v].hdr[5:0]});
        send_write(vecs[v].hdr, vecs[v].data, 1'b0);
        wait_rx_drain("rx_drain");
      end
      #1;
      chk("vec_underrun", {63'd0, underrun}, {63'd0, vecs[v].exp_ur});
      chk("vec_overrun", {63'd0, overrun}, 64'd0);
      chk("vec_hdr_err", {63'd0, hdr_err}, 64'd0);
      pulse_clear();
    end

    // Overrun: second write while the first is still unconsumed.
    rx_ready = 1'b0;
    exp_rx.push_back('{64'h11, 6'd7});
    send_write(8'h07, 64'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovr_first_valid", {63'd0, rx_valid}, 64'd1);
    chk("ovr_first_data", rx_data, 64'h11);
    send_write(8'h07, 64'h22, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovr_flag", {63'd0, overrun}, 64'd1);
    chk("ovr_kept_data", rx_data, 64'h11);
    chk("ovr_kept_valid", {63'd0, rx_valid}, 64'd1);
    rx_ready = 1'b1;
    wait_rx_drain("ovr_drain");
    pulse_clear();

    // Ready arrives in the very cycle the second write completes.
    rx_ready = 1'b0;
    exp_rx.push_back('{64'h33, 6'd7});
    send_write(8'h07, 64'h33, 1'b0);
    exp_rx.push_back('{64'h44, 6'd7});
    send_write(8'h07, 64'h44, 1'b1);
    wait_rx_drain("noovr_drain");
    chk("noovr_flag", {63'd0, overrun}, 64'd0);
    pulse_clear();

    // Reserved opcode, then a normal frame.
    send_hdr(8'h80);
    line_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("hdrerr_flag", {63'd0, hdr_err}, 64'd1);
    chk("hdrerr_no_valid", {63'd0, rx_valid}, 64'd0);
    exp_rx.push_back('{64'h5A, 6'd7});
    send_write(8'h07, 64'h5A, 1'b0);
    wait_rx_drain("hdrerr_next_drain");
    chk("hdrerr_sticky", {63'd0, hdr_err}, 64'd1);
    pulse_clear();
    #1;
    chk("clear_flags", {61'd0, overrun, underrun, hdr_err}, 64'd0);

    // Clear part-way through a write payload.
    send_hdr(8'h0F);
    send_bits(64'h15, 5, 1'b0);
    line_idle();
    pulse_clear();
    repeat (10) @(posedge clk);
    #1;
    chk("clr_wdata_no_valid", {63'd0, rx_valid}, 64'd0);
    exp_rx.push_back('{64'h96, 6'd7});
    send_write(8'h07, 64'h96, 1'b0);
    wait_rx_drain("clr_next_drain");

    // Reset part-way through a read payload.
    tx_data  = 64'hBEEF;
    tx_valid = 1'b1;
    send_hdr(8'h4F);
    tspi_bit(1'b1, 1'b0, so, soe);
    send_bits(64'hF, 4, 1'b0);
    #1;
    chk("rdrst_oe_before", {63'd0, tspi_oe}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rdrst_oe_now", {63'd0, tspi_oe}, 64'd0);
    tspi_clk = 1'b1;
    tspi_din = 1'b1;
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rdrst_oe_after", {63'd0, tspi_oe}, 64'd0);
    chk("rdrst_rx_valid", {63'd0, rx_valid}, 64'd0);
    exp_rx.push_back('{64'h3C, 6'd7});
    send_write(8'h07, 64'h3C, 1'b0);
    wait_rx_drain("rdrst_next_drain");

    repeat (5) @(posedge clk);
    chk("sb_rd_empty", 64'(exp_rd.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tspi_target.md
TSPI_TARGET -- requirements
Module: tspi_target

Interface
REQ-001 SHALL have parameter DataWidth, default 64, maximum payload bits; fixed by the 6-bit length field.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port tspi_clk_i  input  1  TSPI bit clock from the controller, already synchronised to clk_i.
REQ-005 SHALL have port tspi_data_i  input  1  serial line from the controller.
REQ-006 SHALL have ports tspi_data_o and tspi_data_oe_o  output  1 each  serial line to the controller and its drive enable.
REQ-007 SHALL have ports rx_data_o [63:0], rx_len_o [5:0], rx_valid_o  output, and rx_ready_i  input: received write payload with valid/ready handshake.
REQ-008 SHALL have ports tx_data_i [63:0] and tx_valid_i  input, and tx_ready_o  output: read payload source.
REQ-009 SHALL have ports overrun_o, underrun_o and hdr_err_o  output  1 each: sticky error flags, plus clear_i  input  1: synchronous abort and flag clear.

Function
REQ-010 SHALL derive rise_en = tspi_clk_i & ~clk_q and fall_en = ~tspi_clk_i & clk_q, with clk_q a registered copy of tspi_clk_i.
REQ-011 SHALL sample tspi_data_i only in cycles where rise_en=1, and SHALL change tspi_data_o only in cycles where fall_en=1.
REQ-012 SHALL implement states IDLE, HEADER, WDATA, TURN, RDATA.
REQ-013 In IDLE, rise_en with tspi_data_i=0 is the start bit: go to HEADER with bit counter 0; tspi_data_i=1 keeps IDLE.
REQ-014 In HEADER, shift 8 bits MSB-first: hdr[7:6] = opcode (00 write, 01 read, 1x reserved); hdr[5:0] = len, where payload = len+1 bits (1..64).
REQ-015 After the 8th header bit: write goes to WDATA, read goes to TURN, reserved sets hdr_err_o and returns to IDLE.
REQ-016 In WDATA, shift len+1 bits MSB-first into a 64-bit register, right-aligned so the last bit lands in bit 0 and unused upper bits are 0.
REQ-017 On the last WDATA bit, load rx_data_o and rx_len_o, then assert rx_valid_o on the next cycle and return to IDLE.
REQ-018 rx_valid_o SHALL hold, with rx_data_o stable, until a cycle where rx_valid_o & rx_ready_i.
REQ-019 If a write completes while rx_valid_o=1 and rx_ready_i=0, the new payload SHALL be dropped, the old payload kept, and overrun_o set.
REQ-020 If rx_ready_i=1 in the completion cycle, the new payload SHALL be accepted with no overrun.
REQ-021 On entry to TURN, tx_ready_o SHALL pulse one cycle; tx_data_i is latched if tx_valid_i=1, otherwise zeros are latched and underrun_o is set.
REQ-022 TURN SHALL last one rising edge with tspi_data_oe_o=0, then transition to RDATA.
REQ-023 RDATA SHALL assert tspi_data_oe_o on the first fall_en and drive bit[len] down to bit 0, one bit per fall_en.
REQ-024 RDATA SHALL leave after the (len+1)-th rise_en, deasserting tspi_data_oe_o in that same cycle.
REQ-025 clear_i SHALL force IDLE, deassert tspi_data_oe_o and rx_valid_o, and clear all three error flags, taking priority over all other events.
REQ-026 The bit counter SHALL be 6 bits and SHALL never wrap within a frame; len=63 yields exactly 64 bits.

Reset
REQ-027 SHALL reset the state to IDLE, clk_q to 0, and all counters and shift registers to 0.
REQ-028 SHALL reset tspi_data_o, tspi_data_oe_o, rx_valid_o, tx_ready_o and all error flags to 0.
REQ-029 Reset mid-frame SHALL release the line immediately (oe=0) and discard the partial frame.

Structure
REQ-030 tspi_pkg SHALL hold the state enum tspi_tgt_state_e, the opcode constants, TSPI_HDR_W=8 and TSPI_LEN_W=6.
REQ-031 Edge detection SHALL be a sub-module, tspi_edge_detect, with outputs rise_o and fall_o; it is reusable by the controller side.

Verification
REQ-032 Write with hdr 0x07 and payload 0xA5 -> rx_valid_o=1, rx_data_o=0xA5, rx_len_o=7.
REQ-033 Read with hdr 0x4F and tx_data_i=0xBEEF valid -> 16 bits 1011111011101111 on tspi_data_o, oe high for exactly 16 bit periods, tx_ready_o pulses once.
REQ-034 Two back-to-back writes with rx_ready_i=0 -> first payload retained and overrun_o=1; repeat with rx_ready_i=1 at completion -> no overrun.
REQ-035 Read with tx_valid_i=0 -> all-zero bits driven and underrun_o=1.
REQ-036 hdr 0x80 -> hdr_err_o=1, no rx_valid_o, next valid frame is accepted normally.
REQ-037 rst_ni low mid-RDATA -> oe=0 within the same cycle; clear_i mid-WDATA -> IDLE with no rx_valid_o; len=63 write -> 64 bits received.
